// File: rtl/strength_resolver_pkg.sv
// Shared types for the signal-strength resolver: strength codes, settle FSM states
// and the per-driver strength selection helper.
package strength_pkg;

    localparam int STR_W = 3;

    typedef enum logic [2:0] {
        HIGHZ  = 3'd0,
        SMALL  = 3'd1,
        MEDIUM = 3'd2,
        WEAK   = 3'd3,
        LARGE  = 3'd4,
        PULL   = 3'd5,
        STRONG = 3'd6,
        SUPPLY = 3'd7
    } strength_t;

    typedef enum logic {
        UNSETTLED = 1'b0,
        SETTLED   = 1'b1
    } settle_state_t;

    // Strength a driver applies to one bit, chosen by the value it drives.
    function automatic logic [STR_W-1:0] sel_strength(input logic v,
                                                       input logic [STR_W-1:0] s0,
                                                       input logic [STR_W-1:0] s1);
        return v ? s1 : s0;
    endfunction

endpackage

// File: rtl/strength_resolver_bit_resolve.sv
// Combinational resolution of one net bit across N_DRV drivers.
// The winner index port exists only when STRENGTH_RESOLVER_WINNER_EN is defined.
module strength_bit_resolve
    import strength_pkg::*;
#(
    parameter int N_DRV = 2,
    parameter int ID_W  = (N_DRV > 1) ? $clog2(N_DRV) : 1
) (
    input  logic [N_DRV-1:0]       en,
    input  logic [N_DRV-1:0]       val,
    input  logic [N_DRV*STR_W-1:0] str,
    output logic                   res_val,
    output logic                   res_x,
    output logic                   res_z,
    output logic [STR_W-1:0]       res_str
`ifdef STRENGTH_RESOLVER_WINNER_EN
    ,
    output logic [ID_W-1:0]        res_win
`endif
);

    logic [STR_W-1:0] eff_s [N_DRV];
    logic [STR_W-1:0] max_s;
    logic             seen_s;
    logic             first_s;
    logic             x_s;
`ifdef STRENGTH_RESOLVER_WINNER_EN
    logic [ID_W-1:0]  win_s;
`endif

    // Find the strongest driver level, then check the drivers at that level agree.
    always_comb begin
        max_s   = 3'd0;
        seen_s  = 1'b0;
        first_s = 1'b0;
        x_s     = 1'b0;
`ifdef STRENGTH_RESOLVER_WINNER_EN
        win_s   = {ID_W{1'b0}};
`endif
        for (int i = 0; i < N_DRV; i++) begin
            eff_s[i] = en[i] ? str[i*STR_W +: STR_W] : 3'd0;
            if (eff_s[i] > max_s) begin
                max_s = eff_s[i];
            end else begin
                max_s = max_s;
            end
        end
        // Lowest index at the top level sets the reference value and the winner.
        for (int i = 0; i < N_DRV; i++) begin
            if ((max_s != 3'd0) && (eff_s[i] == max_s)) begin
                if (!seen_s) begin
                    seen_s  = 1'b1;
                    first_s = val[i];
`ifdef STRENGTH_RESOLVER_WINNER_EN
                    win_s   = ID_W'(i);
`endif
                end else if (val[i] != first_s) begin
                    x_s = 1'b1;
                end else begin
                    x_s = x_s;
                end
            end else begin
                seen_s = seen_s;
            end
        end
        res_z   = (max_s == 3'd0);
        res_x   = x_s;
        res_str = max_s;
        res_val = seen_s & ~x_s & first_s;
`ifdef STRENGTH_RESOLVER_WINNER_EN
        res_win = win_s;
`endif
    end

endmodule

// File: rtl/strength_resolver.sv
// N-driver multi-bit strength resolver with registered outputs, settle FSM and a
// saturating conflict counter. Define STRENGTH_RESOLVER_WINNER_EN to add win_id.
module strength_resolver
    import strength_pkg::*;
#(
    parameter int N_DRV      = 2,
    parameter int WIDTH      = 1,
    parameter int SETTLE_CYC = 4,
    parameter int CNT_W      = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_DRV-1:0]       drv_en,
    input  logic [N_DRV*WIDTH-1:0] drv_val,
    input  logic [N_DRV*3-1:0]     drv_s0,
    input  logic [N_DRV*3-1:0]     drv_s1,
    input  logic                   clr_cnt,
    output logic [WIDTH-1:0]       out_val,
    output logic [WIDTH-1:0]       out_x,
    output logic [WIDTH-1:0]       out_z,
    output logic [WIDTH*3-1:0]     out_str,
    output logic                   changed,
    output logic                   settled,
    output logic                   conflict,
    output logic [CNT_W-1:0]       conflict_cnt
`ifdef STRENGTH_RESOLVER_WINNER_EN
    ,
    output logic [WIDTH*((N_DRV > 1) ? $clog2(N_DRV) : 1)-1:0] win_id
`endif
);

    localparam int ID_W = (N_DRV > 1) ? $clog2(N_DRV) : 1;
    localparam int SC_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SC_W-1:0]  STAB_LAST = SC_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    logic [WIDTH-1:0]       nv_s, nx_s, nz_s;
    logic [WIDTH*STR_W-1:0] nstr_s;
    logic                   diff_s;
    logic [WIDTH-1:0]       out_val_r, out_x_r, out_z_r;
    logic [WIDTH*STR_W-1:0] out_str_r;
    logic                   changed_r, conflict_r, settled_s;
    logic [CNT_W-1:0]       cnt_r;
    settle_state_t          state_r, state_nxt_s;
    logic [SC_W-1:0]        stab_r, stab_nxt_s;
`ifdef STRENGTH_RESOLVER_WINNER_EN
    logic [WIDTH*ID_W-1:0]  nwin_s, win_r;
`endif

    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        logic [N_DRV-1:0]       bval_s;
        logic [N_DRV*STR_W-1:0] bstr_s;
        for (genvar d = 0; d < N_DRV; d++) begin : g_drv
            assign bval_s[d] = drv_val[d*WIDTH + b];
            assign bstr_s[d*STR_W +: STR_W] =
                sel_strength(bval_s[d], drv_s0[d*3 +: 3], drv_s1[d*3 +: 3]);
        end
        strength_bit_resolve #(.N_DRV(N_DRV), .ID_W(ID_W)) u_res (
            .en      (drv_en),
            .val     (bval_s),
            .str     (bstr_s),
            .res_val (nv_s[b]),
            .res_x   (nx_s[b]),
            .res_z   (nz_s[b]),
            .res_str (nstr_s[b*STR_W +: STR_W])
`ifdef STRENGTH_RESOLVER_WINNER_EN
            ,
            .res_win (nwin_s[b*ID_W +: ID_W])
`endif
        );
    end

    // out_str is deliberately excluded: a strength-only change is not a new word.
    assign diff_s = ({nv_s, nx_s, nz_s} != {out_val_r, out_x_r, out_z_r});

    // Output word, change pulse and conflict flag register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_val_r  <= {WIDTH{1'b0}};
            out_x_r    <= {WIDTH{1'b0}};
            out_z_r    <= {WIDTH{1'b1}};
            out_str_r  <= {(WIDTH*STR_W){1'b0}};
            changed_r  <= 1'b0;
            conflict_r <= 1'b0;
`ifdef STRENGTH_RESOLVER_WINNER_EN
            win_r      <= {(WIDTH*ID_W){1'b0}};
`endif
        end else begin
            out_val_r  <= nv_s;
            out_x_r    <= nx_s;
            out_z_r    <= nz_s;
            out_str_r  <= nstr_s;
            changed_r  <= diff_s;
            conflict_r <= |nx_s;
`ifdef STRENGTH_RESOLVER_WINNER_EN
            win_r      <= nwin_s;
`endif
        end
    end

    // Saturating conflict counter; clear wins over a simultaneous conflict.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr_cnt) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if ((|nx_s) && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Settle FSM state and stability counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= UNSETTLED;
            stab_r  <= {SC_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            stab_r  <= stab_nxt_s;
        end
    end

    // Settle FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        stab_nxt_s  = stab_r;
        case (state_r)
            UNSETTLED: begin
                if (diff_s) begin
                    stab_nxt_s = {SC_W{1'b0}};
                end else if (stab_r == STAB_LAST) begin
                    state_nxt_s = SETTLED;
                    stab_nxt_s  = {SC_W{1'b0}};
                end else begin
                    stab_nxt_s = stab_r + SC_W'(1);
                end
            end
            SETTLED: begin
                if (diff_s) begin
                    state_nxt_s = UNSETTLED;
                    stab_nxt_s  = {SC_W{1'b0}};
                end else begin
                    state_nxt_s = SETTLED;
                end
            end
            default: begin
                state_nxt_s = UNSETTLED;
                stab_nxt_s  = {SC_W{1'b0}};
            end
        endcase
    end

    // Settle FSM output decode.
    always_comb begin
        case (state_r)
            SETTLED: settled_s = 1'b1;
            default: settled_s = 1'b0;
        endcase
    end

    assign out_val      = out_val_r;
    assign out_x        = out_x_r;
    assign out_z        = out_z_r;
    assign out_str      = out_str_r;
    assign changed      = changed_r;
    assign settled      = settled_s;
    assign conflict     = conflict_r;
    assign conflict_cnt = cnt_r;
`ifdef STRENGTH_RESOLVER_WINNER_EN
    assign win_id       = win_r;
`endif

endmodule
